// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture path: FSM state encoding, trigger mode codes
// and default sample width.
package adc_pkg;

    localparam int SAMPLE_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RDY  = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_DONE      = 3'd4
    } adc_state_e;

    localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
    localparam logic [1:0] TRIG_RISING    = 2'd1;
    localparam logic [1:0] TRIG_FALLING   = 2'd2;

endpackage

// File: rtl/adc_level_trigger.sv
// Signed level-crossing detector for one ADC channel: remembers the previous valid sample
// and flags a rising or falling crossing of the threshold on the current one.
module adc_level_trigger
    import adc_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
    input  logic                adc_data_clk,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                sample_en_i,
    input  logic [1:0]          mode_i,
    input  logic [SAMPLE_W-1:0] level_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic                trig_hit_o
);

    logic [SAMPLE_W-1:0] prev_q;
    logic                prev_valid_q;
    logic                rise_hit;
    logic                fall_hit;

    always_ff @(posedge adc_data_clk) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (clear_i) begin
            prev_valid_q <= 1'b0;
        end else if (sample_en_i) begin
            prev_q       <= sample_i;
            prev_valid_q <= 1'b1;
        end
    end

    // The first sample after clear only seeds prev_q and can never trigger.
    always_comb begin
        rise_hit   = ($signed(prev_q) < $signed(level_i)) && ($signed(sample_i) >= $signed(level_i));
        fall_hit   = ($signed(prev_q) > $signed(level_i)) && ($signed(sample_i) <= $signed(level_i));
        trig_hit_o = sample_en_i && prev_valid_q &&
                     (((mode_i == TRIG_RISING) && rise_hit) || ((mode_i == TRIG_FALLING) && fall_hit));
    end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Armed, optionally triggered and decimated capture of dual-channel ADC samples into the
// ADC-to-pipe FIFO, with busy/done/overflow status for the host side.
module adc_capture_sequencer
    import adc_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    parameter int COUNT_W  = 24,
    parameter int DECIM_W  = 8
) (
    input  logic                  adc_data_clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [COUNT_W-1:0]    cfg_count,
    input  logic [DECIM_W-1:0]    cfg_decim,
    input  logic [1:0]            cfg_trig_mode,
    input  logic [SAMPLE_W-1:0]   cfg_trig_level,
    input  logic                  adc_rdy,
    input  logic                  adc_data_valid,
    input  logic [SAMPLE_W-1:0]   adc_data_1,
    input  logic [SAMPLE_W-1:0]   adc_data_2,
    input  logic                  fifo_prog_full,
    input  logic                  fifo_busy,
    output logic                  fifo_wr_en,
    output logic [2*SAMPLE_W-1:0] fifo_din,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [2:0]            state_o
);

    // FIFO handshake: fifo_wr_en is a one-cycle push per accepted sample; fifo_prog_full or
    // fifo_busy high in the cycle a sample is due means "not ready" and the sample is dropped.

    adc_state_e            state_q, state_d;
    logic [COUNT_W-1:0]    remaining_q, remaining_d;
    logic [DECIM_W-1:0]    decim_cnt_q, decim_cnt_d;
    logic [DECIM_W-1:0]    decim_cfg_q;
    logic [1:0]            mode_q;
    logic [SAMPLE_W-1:0]   level_q;
    logic                  overflow_q, overflow_d;
    logic                  wr_en_q, wr_en_d;
    logic [2*SAMPLE_W-1:0] din_q, din_d;

    logic arm_accept;
    logic trig_hit;
    logic take_sample;

    assign arm_accept  = (state_q == ST_IDLE) && arm && !abort;
    assign take_sample = ((state_q == ST_CAPTURE) && adc_rdy && adc_data_valid) ||
                         ((state_q == ST_WAIT_TRIG) && trig_hit);

    adc_level_trigger #(.SAMPLE_W(SAMPLE_W)) u_ch1_trigger (
        .adc_data_clk (adc_data_clk),
        .reset        (reset),
        .clear_i      (arm_accept),
        .sample_en_i  ((state_q == ST_WAIT_TRIG) && adc_data_valid),
        .mode_i       (mode_q),
        .level_i      (level_q),
        .sample_i     (adc_data_1),
        .trig_hit_o   (trig_hit)
    );

    always_ff @(posedge adc_data_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            decim_cnt_q <= '0;
            decim_cfg_q <= '0;
            mode_q      <= TRIG_IMMEDIATE;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            decim_cnt_q <= decim_cnt_d;
            overflow_q  <= overflow_d;
            wr_en_q     <= wr_en_d;
            din_q       <= din_d;
            if (arm_accept) begin
                decim_cfg_q <= cfg_decim;
                mode_q      <= cfg_trig_mode;
                level_q     <= cfg_trig_level;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        decim_cnt_d = '0;
        overflow_d  = overflow_q;
        wr_en_d     = 1'b0;
        din_d       = din_q;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d     = ST_WAIT_RDY;
                    remaining_d = cfg_count;
                    overflow_d  = 1'b0;
                end
            end
            ST_WAIT_RDY: begin
                if (adc_rdy && !fifo_busy) begin
                    state_d = (remaining_q == '0) ? ST_DONE : ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if ((mode_q != TRIG_RISING) && (mode_q != TRIG_FALLING)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                decim_cnt_d = decim_cnt_q;
                // Losing the ADC mid-capture drops samples; resume from WAIT_RDY with the count kept.
                if (!adc_rdy) begin
                    overflow_d = 1'b1;
                    state_d    = ST_WAIT_RDY;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // The trigger sample enters here too, so it is always the first due sample.
        if (take_sample) begin
            decim_cnt_d = (decim_cnt_q == decim_cfg_q) ? '0 : decim_cnt_q + DECIM_W'(1);
            if (decim_cnt_q == '0) begin
                if (!fifo_prog_full && !fifo_busy) begin
                    wr_en_d     = 1'b1;
                    din_d       = {adc_data_1, adc_data_2};
                    remaining_d = remaining_q - COUNT_W'(1);
                    state_d     = (remaining_q == COUNT_W'(1)) ? ST_DONE : ST_CAPTURE;
                end else begin
                    overflow_d = 1'b1;
                    state_d    = ST_CAPTURE;
                end
            end
        end

        if (abort) begin
            state_d     = ST_IDLE;
            wr_en_d     = 1'b0;
            overflow_d  = overflow_q;
            remaining_d = remaining_q;
        end
    end

    assign fifo_wr_en = wr_en_q;
    assign fifo_din   = din_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign overflow   = overflow_q;
    assign state_o    = state_q;

endmodule
